alu_exec_stage: RTL and testbench

// - Registered execute stage directly downstream of the ALU control decoder: consumes its 4-bit
//   ALU operation code plus two XLEN operands, produces result + zero flag one cycle later.
// - valid/ready handshake both sides; 2-entry output buffer (main + skid) gives full throughput.
// - Feeds branch resolution (zero flag) and writeback (result + destination tag).

---
 rtl/alu_exec_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_exec_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with a two-entry output buffer.
// Consumes an ALU operation code plus two operands and produces a result,
// a zero flag and a passthrough destination tag one cycle after acceptance.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side. Upstream data is sampled only on such an accept edge.
// Once o_valid is raised, o_result/o_zero/o_tag (and o_overflow) are held
// until a drain. o_ready comes from a flop, so it depends only on state
// already stored in the stage.
//
// Optional feature macro: ALU_OVF_FLAG_EN adds the o_overflow port, which
// reports signed overflow for ADD/SUB. It is registered with the result and
// also stored in the skid entry.

module alu_exec_stage #(
    parameter int XLEN  = 64,
    parameter int OP_W  = 4,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [OP_W-1:0]  i_alu_op,
    input  logic [XLEN-1:0]  i_op_a,
    input  logic [XLEN-1:0]  i_op_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
`ifdef ALU_OVF_FLAG_EN
    ,
    output logic             o_overflow
`endif
);

    // ALU operation codes as produced by the ALU control decoder
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(5);

    // Output buffer occupancy:
    // EMPTY = nothing valid
    // ONE   = output register valid, skid empty
    // FULL  = output and skid registers both valid
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    buf_state_e state_q, state_d;

    logic             ready_q, ready_d;
    logic             accept;
    logic             drain;
    logic             out_valid;

    // Combinational ALU results for the operation currently presented
    logic [XLEN-1:0]  sum;
    logic [XLEN-1:0]  diff;
    logic [XLEN-1:0]  calc_result;
    logic             calc_zero;

    // Output register (entry at the head of the FIFO)
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic             out_zero_q,   out_zero_d;
    logic [TAG_W-1:0] out_tag_q,    out_tag_d;

    // Skid register (second entry, used only while the output stalls)
    logic [XLEN-1:0]  skid_result_q, skid_result_d;
    logic             skid_zero_q,   skid_zero_d;
    logic [TAG_W-1:0] skid_tag_q,    skid_tag_d;

`ifdef ALU_OVF_FLAG_EN
    logic             calc_ovf;
    logic             out_ovf_q,  out_ovf_d;
    logic             skid_ovf_q, skid_ovf_d;
`endif

    // Carry out of the MSB is discarded: ADD and SUB wrap modulo 2^XLEN.
    assign sum  = i_op_a + i_op_b;
    assign diff = i_op_a - i_op_b;

    // ALU result select. NOP and undefined codes give a zero result.
    always_comb begin
        calc_result = '0;
        case (i_alu_op)
            OP_ADD:  calc_result = sum;
            OP_SUB:  calc_result = diff;
            OP_AND:  calc_result = i_op_a & i_op_b;
            OP_OR:   calc_result = i_op_a | i_op_b;
            OP_XOR:  calc_result = i_op_a ^ i_op_b;
            default: calc_result = '0;
        endcase
        calc_zero = (calc_result == '0);
    end

`ifdef ALU_OVF_FLAG_EN
    // Signed overflow. ADD overflows when the operand signs match and the
    // result sign differs. SUB overflows when the operand signs differ and
    // the result sign differs from A. Every other op reports 0.
    always_comb begin
        calc_ovf = 1'b0;
        case (i_alu_op)
            OP_ADD:  calc_ovf = (i_op_a[XLEN-1] == i_op_b[XLEN-1]) &&
                                (sum[XLEN-1]    != i_op_a[XLEN-1]);
            OP_SUB:  calc_ovf = (i_op_a[XLEN-1] != i_op_b[XLEN-1]) &&
                                (diff[XLEN-1]   != i_op_a[XLEN-1]);
            default: calc_ovf = 1'b0;
        endcase
    end
`endif

    assign out_valid = (state_q != BUF_EMPTY);
    assign accept    = i_valid & ready_q;
    assign drain     = out_valid & i_ready;

    // Buffer state register; reset discards any entries in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= BUF_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic for buffer occupancy
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) state_d = BUF_ONE;
            end
            BUF_ONE: begin
                if (accept && !drain)      state_d = BUF_FULL;
                else if (!accept && drain) state_d = BUF_EMPTY;
                else                       state_d = BUF_ONE;
            end
            BUF_FULL: begin
                if (drain) state_d = BUF_ONE;
            end
            default: state_d = BUF_EMPTY;
        endcase
        // ready follows the next state, so it is low exactly while FULL
        ready_d = (state_d != BUF_FULL);
    end

    // Output decode from the registered state
    always_comb begin
        o_valid = out_valid;
        o_ready = ready_q;
    end

    // Datapath steering: the output register loads new data or the skid
    // entry, and the skid register captures new data while the output stalls.
    always_comb begin
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_tag_d     = out_tag_q;
        skid_result_d = skid_result_q;
        skid_zero_d   = skid_zero_q;
        skid_tag_d    = skid_tag_q;
`ifdef ALU_OVF_FLAG_EN
        out_ovf_d     = out_ovf_q;
        skid_ovf_d    = skid_ovf_q;
`endif
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    out_result_d = calc_result;
                    out_zero_d   = calc_zero;
                    out_tag_d    = i_tag;
`ifdef ALU_OVF_FLAG_EN
                    out_ovf_d    = calc_ovf;
`endif
                end
            end
            BUF_ONE: begin
                if (accept && drain) begin
                    out_result_d = calc_result;
                    out_zero_d   = calc_zero;
                    out_tag_d    = i_tag;
`ifdef ALU_OVF_FLAG_EN
                    out_ovf_d    = calc_ovf;
`endif
                end else if (accept) begin
                    skid_result_d = calc_result;
                    skid_zero_d   = calc_zero;
                    skid_tag_d    = i_tag;
`ifdef ALU_OVF_FLAG_EN
                    skid_ovf_d    = calc_ovf;
`endif
                end
            end
            BUF_FULL: begin
                if (drain) begin
                    out_result_d = skid_result_q;
                    out_zero_d   = skid_zero_q;
                    out_tag_d    = skid_tag_q;
`ifdef ALU_OVF_FLAG_EN
                    out_ovf_d    = skid_ovf_q;
`endif
                end
            end
            default: begin
                out_result_d = out_result_q;
            end
        endcase
    end

    // Output and skid data registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_tag_q     <= '0;
            skid_result_q <= '0;
            skid_zero_q   <= 1'b0;
            skid_tag_q    <= '0;
`ifdef ALU_OVF_FLAG_EN
            out_ovf_q     <= 1'b0;
            skid_ovf_q    <= 1'b0;
`endif
        end else begin
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_tag_q     <= out_tag_d;
            skid_result_q <= skid_result_d;
            skid_zero_q   <= skid_zero_d;
            skid_tag_q    <= skid_tag_d;
`ifdef ALU_OVF_FLAG_EN
            out_ovf_q     <= out_ovf_d;
            skid_ovf_q    <= skid_ovf_d;
`endif
        end
    end

    assign o_result = out_result_q;
    assign o_zero   = out_zero_q;
    assign o_tag    = out_tag_q;
`ifdef ALU_OVF_FLAG_EN
    assign o_overflow = out_ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed and randomized bench for alu_exec_stage.
// The reference model is an in-order queue of expected outputs. Each entry
// is computed with plain arithmetic from the operation rules. The stage
// holds at most two entries, so o_ready is expected whenever the queue
// holds fewer than two.

module tb_alu_exec_stage;
  localparam int XLEN  = 64;
  localparam int OP_W  = 4;
  localparam int TAG_W = 5;
  localparam int EW    = TAG_W + 2 + XLEN;

  localparam logic [XLEN-1:0] ALL1 = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMAX = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [OP_W-1:0]  i_alu_op;
  logic [XLEN-1:0]  i_op_a;
  logic [XLEN-1:0]  i_op_b;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [XLEN-1:0]  o_result;
  logic             o_zero;
  logic [TAG_W-1:0] o_tag;
  logic             ovf_obs;

  int n_tests = 0;
  int n_fail  = 0;

  // expected entries packed as {tag, overflow, zero, result}
  logic [EW-1:0] exp_q[$];

  alu_exec_stage #(.XLEN(XLEN), .OP_W(OP_W), .TAG_W(TAG_W)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_alu_op (i_alu_op),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .i_tag    (i_tag),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_zero   (o_zero),
    .o_tag    (o_tag)
`ifdef ALU_OVF_FLAG_EN
    ,
    .o_overflow (ovf_obs)
`endif
  );

`ifndef ALU_OVF_FLAG_EN
  assign ovf_obs = 1'b0;
`endif

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] model(input logic [OP_W-1:0] op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b,
                                          input logic [TAG_W-1:0] tag);
    logic [XLEN-1:0] r;
    logic ovf;
    logic sa, sb, sr;
    r   = '0;
    ovf = 1'b0;
    case (op)
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      default: r = '0;
    endcase
`ifdef ALU_OVF_FLAG_EN
    // signed overflow: the result sign disagrees with the true signed result
    sa = a[XLEN-1];
    sb = b[XLEN-1];
    sr = r[XLEN-1];
    if (op == 4'd1) ovf = (sa == sb) && (sr != sa);
    if (op == 4'd2) ovf = (sa != sb) && (sr != sa);
`else
    sa = 1'b0;
    sb = 1'b0;
    sr = 1'b0;
`endif
    return {tag, ovf, (r == '0), r};
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  // one clock: check the handshake against the model at the falling edge,
  // update the model, then step past the rising edge
  task automatic tick();
    bit m_valid;
    bit m_ready;
    logic [EW-1:0] head;
    @(negedge clk);
    m_valid = (exp_q.size() != 0);
    m_ready = (exp_q.size() < 2);
    chk("sb_valid", 128'(o_valid), 128'(m_valid));
    chk("sb_ready", 128'(o_ready), 128'(m_ready));
    if (m_valid && i_ready) begin
      head = exp_q.pop_front();
      chk("sb_data", 128'({o_tag, ovf_obs, o_zero, o_result}), 128'(head));
    end
    if (i_valid && m_ready)
      exp_q.push_back(model(i_alu_op, i_op_a, i_op_b, i_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    i_valid  = 1'b1;
    i_alu_op = op;
    i_op_a   = a;
    i_op_b   = b;
    i_tag    = tag;
  endtask

  task automatic send(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    drive(op, a, b, tag);
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    drive(4'd1, 64'd3, 64'd4, 5'd9);
    repeat (cycles) @(posedge clk);
    #1;
    rst     = 1'b0;
    i_valid = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return ALL1;
      2: return SMAX;
      3: return SMIN;
      4: return XLEN'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_alu_op = '0;
    i_op_a   = '0;
    i_op_b   = '0;
    i_tag    = '0;

    // reset held two cycles with valid traffic
    do_reset(2);
    chk("rst_valid",  128'(o_valid), 128'(0));
    chk("rst_result", 128'(o_result), 128'(0));
    chk("rst_zero",   128'(o_zero), 128'(0));
    chk("rst_tag",    128'(o_tag), 128'(0));
    chk("rst_ovf",    128'(ovf_obs), 128'(0));
    chk("rst_ready",  128'(o_ready), 128'(1));

    // back-to-back ops with downstream always ready
    i_ready = 1'b1;
    send(4'b0001, 64'd5, 64'd7, 5'd1);
    chk("add_valid", 128'(o_valid), 128'(1));
    chk("add_res",   128'(o_result), 128'(12));
    chk("add_z",     128'(o_zero), 128'(0));
    chk("add_tag",   128'(o_tag), 128'(1));
    send(4'b0010, 64'd9, 64'd9, 5'd2);
    chk("sub_res", 128'(o_result), 128'(0));
    chk("sub_z",   128'(o_zero), 128'(1));
    send(4'b0011, 64'hF0, 64'h3C, 5'd3);
    chk("and_res", 128'(o_result), 128'(64'h30));
    send(4'b0100, 64'hF0, 64'h0F, 5'd4);
    chk("or_res", 128'(o_result), 128'(64'hFF));
    send(4'b0101, 64'hFF, 64'h0F, 5'd5);
    chk("xor_res", 128'(o_result), 128'(64'hF0));
    send(4'b1111, 64'hFF, 64'h0F, 5'd6);
    chk("nop_res", 128'(o_result), 128'(0));
    chk("nop_z",   128'(o_zero), 128'(1));
    chk("nop_tag", 128'(o_tag), 128'(6));

    // wrap-around
    send(4'b0001, ALL1, 64'd1, 5'd7);
    chk("wrap_add_res", 128'(o_result), 128'(0));
    chk("wrap_add_z",   128'(o_zero), 128'(1));
    chk("wrap_add_ovf", 128'(ovf_obs), 128'(0));
    send(4'b0010, 64'd0, 64'd1, 5'd8);
    chk("wrap_sub_res", 128'(o_result), 128'(ALL1));
    chk("wrap_sub_z",   128'(o_zero), 128'(0));
    chk("wrap_sub_ovf", 128'(ovf_obs), 128'(0));

`ifdef ALU_OVF_FLAG_EN
    send(4'b0001, SMAX, 64'd1, 5'd9);
    chk("ovf_add_res", 128'(o_result), 128'(SMIN));
    chk("ovf_add",     128'(ovf_obs), 128'(1));
    send(4'b0010, SMIN, 64'd1, 5'd10);
    chk("ovf_sub_res", 128'(o_result), 128'(SMAX));
    chk("ovf_sub",     128'(ovf_obs), 128'(1));
`endif

    i_valid = 1'b0;
    tick();
    chk("idle_valid", 128'(o_valid), 128'(0));

    // backpressure: tags 1,2,3 with downstream stalled
    i_ready = 1'b0;
    send(4'b0001, 64'd1, 64'd0, 5'd1);
    send(4'b0001, 64'd2, 64'd0, 5'd2);
    drive(4'b0001, 64'd3, 64'd0, 5'd3);
    tick();
    tick();
    chk("bp_ready", 128'(o_ready), 128'(0));
    chk("bp_valid", 128'(o_valid), 128'(1));
    chk("bp_tag1",  128'(o_tag), 128'(1));
    chk("bp_res1",  128'(o_result), 128'(1));
    i_ready = 1'b1;
    tick();
    chk("bp_tag2", 128'(o_tag), 128'(2));
    tick();
    chk("bp_tag3", 128'(o_tag), 128'(3));
    chk("bp_res3", 128'(o_result), 128'(3));
    i_valid = 1'b0;
    tick();
    chk("bp_empty", 128'(o_valid), 128'(0));
    chk("bp_q",     128'(exp_q.size()), 128'(0));

    // reset while FULL
    i_ready = 1'b0;
    send(4'b0101, 64'hA, 64'h5, 5'd11);
    send(4'b0101, 64'hB, 64'h5, 5'd12);
    i_valid = 1'b0;
    tick();
    chk("full_ready", 128'(o_ready), 128'(0));
    do_reset(1);
    chk("mid_rst_valid", 128'(o_valid), 128'(0));
    chk("mid_rst_ready", 128'(o_ready), 128'(1));
    i_ready = 1'b1;
    tick();
    chk("mid_rst_gone", 128'(o_valid), 128'(0));

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      i_valid  = ($urandom_range(0, 3) != 0);
      i_ready  = ($urandom_range(0, 2) != 0);
      i_alu_op = OP_W'($urandom_range(0, 15));
      i_op_a   = rand_operand();
      i_op_b   = rand_operand();
      i_tag    = TAG_W'($urandom);
      tick();
    end

    // drain everything
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) tick();
    chk("final_q",     128'(exp_q.size()), 128'(0));
    chk("final_valid", 128'(o_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
